// File: rtl/cntr8_sched.sv
// cntr8_sched: two-port round-robin controller that sequences a shared up/down load counter through count jobs
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   reqN/dirN/startN/tgtN     job request, direction (1=up), start and target value from requester N
//   gntN, doneN               one-cycle pulses: job N accepted / job N finished
//   ctr_load/ctr_inc/ctr_d_in counter controls; ctr_d_out is the counter's current value
//   busy, owner, steps        not idle, current/last granted requester, counting cycles of current/last job
//   o_state                   IDLE=0, LOAD=1, RUN=2, DONE=3
module cntr8_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             dir0,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] tgt0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             dir1,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] tgt1,
  output logic             gnt1,
  output logic             done1,
  output logic             ctr_load,
  output logic             ctr_inc,
  output logic [WIDTH-1:0] ctr_d_in,
  input  logic [WIDTH-1:0] ctr_d_out,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] steps,
  output logic [1:0]       o_state
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] hold, j_start, j_tgt;
  logic j_dir, last, hit, counting, any_req, win, take;
  assign any_req = req0 | req1;
  // last holds the most recent winner; it resets to 1 so req0 wins the first tie
  assign win = (req0 & req1) ? ~last : req1;
  assign take = state == IDLE && any_req;
  assign hit = state == RUN && ctr_d_out == j_tgt;
  assign counting = state == RUN && !hit;
  assign busy = state != IDLE;
  assign o_state = state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (any_req ? LOAD : IDLE) :
               state == LOAD ? RUN :
               state == RUN  ? (hit ? DONE : RUN) : IDLE;
  // the counter only runs free while counting; every other cycle reloads a value to freeze it
  always_comb begin
    ctr_load = !counting;
    ctr_inc  = counting ? j_dir : 1'b1;
    ctr_d_in = state == IDLE ? hold : state == LOAD ? j_start : j_tgt;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hold    <= '0;
      j_start <= '0;
      j_tgt   <= '0;
      j_dir   <= 1'b1;
      owner   <= 1'b0;
      last    <= 1'b1;
      steps   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      gnt0  <= take && !win;
      gnt1  <= take && win;
      done0 <= hit && !owner;
      done1 <= hit && owner;
      if (take) begin
        owner   <= win;
        last    <= win;
        steps   <= '0;
        j_dir   <= win ? dir1 : dir0;
        j_start <= win ? start1 : start0;
        j_tgt   <= win ? tgt1 : tgt0;
      end
      if (counting) steps <= steps + WIDTH'(1);
      if (state == DONE) hold <= j_tgt;
    end
endmodule

// File: tb/tb_cntr8_sched.sv
// tb_cntr8_sched: table-driven, hand-written and randomized checks of cntr8_sched driving a behavioural counter
module tb_cntr8_sched;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic dir [2];
  logic [7:0] start [2], tgt [2];
  logic gnt0, gnt1, done0, done1, ctr_load, ctr_inc, busy, owner;
  logic [7:0] ctr_d_in, steps;
  logic [7:0] ctr_d_out = 8'h00;
  logic [1:0] o_state, gnt, done;
  logic jdir [2];
  logic [7:0] jstart [2], jtgt [2];
  logic lastg = 1'b1;
  int n_cmp = 0, n_fail = 0, n_gnt1 = 0;
  typedef struct { int p; logic d; logic [7:0] s; logic [7:0] t; logic [7:0] e; } vec_t;
  vec_t tbl [6];
  assign gnt = {gnt1, gnt0};
  assign done = {done1, done0};
  cntr8_sched #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req[0]), .dir0(dir[0]), .start0(start[0]), .tgt0(tgt[0]), .gnt0(gnt0), .done0(done0),
    .req1(req[1]), .dir1(dir[1]), .start1(start[1]), .tgt1(tgt[1]), .gnt1(gnt1), .done1(done1),
    .ctr_load(ctr_load), .ctr_inc(ctr_inc), .ctr_d_in(ctr_d_in), .ctr_d_out(ctr_d_out),
    .busy(busy), .owner(owner), .steps(steps), .o_state(o_state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ctr_d_out <= ctr_load ? ctr_d_in : ctr_inc ? ctr_d_out + 8'd1 : ctr_d_out - 8'd1;
  always @(negedge clk) if (gnt1) n_gnt1++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_steps(input logic d, input logic [7:0] s, input logic [7:0] t);
    return d ? t - s : s - t;
  endfunction
  task automatic raise(input int p, input logic d, input logic [7:0] s, input logic [7:0] t);
    req[p] = 1'b1;
    dir[p] = d;
    start[p] = s;
    tgt[p] = t;
    jdir[p] = d;
    jstart[p] = s;
    jtgt[p] = t;
  endtask
  task automatic serve(input int p, input logic [7:0] e, input string nm);
    int k, zeros;
    logic [7:0] v;
    logic [1:0] eg;
    eg = (p == 1) ? 2'b10 : 2'b01;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 2'b00 && k < 200);
    chk({nm, " gnt"}, gnt, eg);
    if (gnt == 2'b00) return;
    lastg = p[0];
    chk({nm, " owner"}, owner, p);
    chk({nm, " load_state"}, o_state, 1);
    req[p] = 1'b0;
    dir[p] = 1'($urandom);
    start[p] = 8'($urandom);
    tgt[p] = 8'($urandom);
    k = 0;
    zeros = 0;
    v = jstart[p];
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk({nm, " gnt_pulse"}, gnt, 0);
      if (!done[p] && k <= int'(e) + 1) begin
        chk({nm, " walk"}, ctr_d_out, v);
        v = jdir[p] ? v + 8'd1 : v - 8'd1;
      end
      if (!ctr_load) zeros++;
    end while (!done[p] && k < 300);
    chk({nm, " latency"}, k + 1, int'(e) + 3);
    chk({nm, " steps"}, steps, e);
    chk({nm, " free_cycles"}, zeros, e);
    chk({nm, " final"}, ctr_d_out, jtgt[p]);
    chk({nm, " done_state"}, o_state, 3);
    chk({nm, " other_done"}, done[1-p], 0);
    @(negedge clk);
    chk({nm, " idle_state"}, {busy, o_state}, 0);
    chk({nm, " frozen"}, ctr_d_out, jtgt[p]);
    chk({nm, " done_pulse"}, done, 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      dir[i] = 1'b0;
      start[i] = 8'h00;
      tgt[i] = 8'h00;
    end
    tbl[0] = '{0, 1'b1, 8'h55, 8'h55, 8'h00};
    tbl[1] = '{1, 1'b1, 8'hF0, 8'h10, 8'h20};
    tbl[2] = '{0, 1'b0, 8'h00, 8'hFF, 8'h01};
    tbl[3] = '{1, 1'b1, 8'hFF, 8'h00, 8'h01};
    tbl[4] = '{0, 1'b0, 8'h30, 8'h20, 8'h10};
    tbl[5] = '{1, 1'b1, 8'h7E, 8'h81, 8'h03};
    repeat (3) @(negedge clk);
    chk("rst ctl", {ctr_load, ctr_inc, busy}, 3'b110);
    chk("rst d_in", ctr_d_in, 0);
    chk("rst state", o_state, 0);
    chk("rst owner_steps", {owner, steps}, 0);
    chk("rst pulses", {gnt, done}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst counter", ctr_d_out, 0);
    // both requesters at once after reset: req0 first, then req1
    raise(0, 1'b1, 8'h0F, 8'h14);
    raise(1, 1'b0, 8'h02, 8'hFE);
    serve(0, 8'd5, "pair0");
    serve(1, 8'd4, "pair1");
    chk("pair owner", owner, 1);
    for (int i = 0; i < 6; i++) begin
      raise(tbl[i].p, tbl[i].d, tbl[i].s, tbl[i].t);
      serve(tbl[i].p, tbl[i].e, $sformatf("tbl%0d", i));
    end
    // a request withdrawn before its grant is never serviced
    begin
      int g1;
      g1 = n_gnt1;
      raise(0, 1'b1, 8'h10, 8'h30);
      @(negedge clk);
      chk("drop gnt0", gnt, 2'b01);
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      raise(1, 1'b1, 8'h40, 8'h44);
      repeat (2) @(negedge clk);
      req[1] = 1'b0;
      for (int k = 0; k < 60 && !done0; k++) @(negedge clk);
      chk("drop done0", done0, 1);
      repeat (4) @(negedge clk);
      chk("drop no_gnt1", n_gnt1, g1);
      lastg = 1'b0;
    end
    // reset in the middle of a counting run
    raise(0, 1'b1, 8'h00, 8'h80);
    @(negedge clk);
    chk("mid gnt0", gnt, 2'b01);
    req[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid run", o_state, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst state", {busy, o_state}, 0);
    chk("mid rst d_in", {ctr_load, ctr_d_in}, 9'h100);
    chk("mid rst steps", steps, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid rst no_done", done, 0);
    end
    reset_n = 1'b1;
    lastg = 1'b1;
    chk("mid rst counter", ctr_d_out, 0);
    raise(1, 1'b0, 8'h05, 8'h03);
    serve(1, 8'd2, "post_rst");
    // randomized mix of single and simultaneous requests
    for (int r = 0; r < 30; r++) begin
      logic [1:0] pat;
      int f;
      pat = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++)
        if (pat[p]) begin
          logic d;
          logic [7:0] s, off;
          d = 1'($urandom_range(0, 1));
          s = 8'($urandom);
          off = 8'($urandom_range(0, 40));
          raise(p, d, s, d ? s + off : s - off);
        end
      f = (pat == 2'b11) ? (lastg ? 0 : 1) : (pat == 2'b10 ? 1 : 0);
      serve(f, exp_steps(jdir[f], jstart[f], jtgt[f]), "rand_first");
      if (pat == 2'b11) serve(1 - f, exp_steps(jdir[1-f], jstart[1-f], jtgt[1-f]), "rand_second");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
